// File: rtl/y_tile_pack_wb.sv
// y_tile_pack_wb: packs TPL signed tiles into a line and writes it to an output buffer with ready handshake.
// Optional YWB_MAXABS_EN tracks per-vector max |lane| on maxabs.
module y_tile_pack_wb #(
  parameter int TILE_SIZE  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DATA_W     = 256,
  parameter int D          = 256,
  parameter int OUT_DEPTH  = 64,
  parameter int OUT_ADDR_W = $clog2(OUT_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            soft_clr,
  input  logic                            y_axis_TVALID,
  output logic                            y_axis_TREADY,
  input  logic [TILE_SIZE*DATA_WIDTH-1:0] y_axis_TDATA,
  output logic                            wr_en,
  input  logic                            wr_ready,
  output logic [OUT_ADDR_W-1:0]           wr_addr,
  output logic [DATA_W-1:0]               wr_data,
  output logic                            vec_done,
  output logic [15:0]                     vec_cnt,
  output logic                            busy,
  output logic [15:0]                     maxabs
);
  localparam int TW   = TILE_SIZE * DATA_WIDTH;
  localparam int TPL  = DATA_W / TW;
  localparam int LPV  = D / (DATA_W / DATA_WIDTH);
  localparam int TI_W = TPL > 1 ? $clog2(TPL) : 1;
  localparam int LC_W = LPV > 1 ? $clog2(LPV) : 1;
  typedef enum logic {FILL, WRITE} state_t;
  state_t state, state_d;
  logic [TI_W-1:0] tile_idx;
  logic [LC_W-1:0] line_cnt;
  logic fire, last_tile, wr_done, last_line;
  assign y_axis_TREADY = state == FILL;
  assign wr_en         = state == WRITE;
  assign fire          = y_axis_TVALID && y_axis_TREADY;
  assign last_tile     = tile_idx == TI_W'(TPL - 1);
  assign wr_done       = wr_en && wr_ready;
  assign last_line     = line_cnt == LC_W'(LPV - 1);
  assign busy          = tile_idx != '0 || state == WRITE;
  always_comb begin
    state_d = soft_clr ? FILL : (fire && last_tile) ? WRITE : wr_done ? FILL : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FILL;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tile_idx <= '0;
      line_cnt <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      vec_done <= 1'b0;
      vec_cnt  <= '0;
    end else if (soft_clr) begin
      tile_idx <= '0;
      line_cnt <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      vec_done <= 1'b0;
    end else begin
      vec_done <= wr_done && last_line;
      if (fire) begin
        tile_idx <= last_tile ? '0 : tile_idx + 1'b1;
        for (int k = 0; k < TPL; k++)
          if (tile_idx == TI_W'(k)) wr_data[k*TW +: TW] <= y_axis_TDATA;
      end
      if (wr_done) begin
        wr_data  <= '0;
        wr_addr  <= wr_addr == OUT_ADDR_W'(OUT_DEPTH - 1) ? '0 : wr_addr + 1'b1;
        line_cnt <= last_line ? '0 : line_cnt + 1'b1;
        if (last_line) vec_cnt <= vec_cnt + 16'd1;
      end
    end
`ifdef YWB_MAXABS_EN
  logic [DATA_WIDTH-1:0] run_max, tile_max, mag;
  function automatic logic [DATA_WIDTH-1:0] abs_sat(input logic [DATA_WIDTH-1:0] v);
    return !v[DATA_WIDTH-1] ? v : v == {1'b1, {(DATA_WIDTH-1){1'b0}}} ? {1'b0, {(DATA_WIDTH-1){1'b1}}} : -v;
  endfunction
  always_comb begin
    tile_max = '0;
    mag      = '0;
    for (int i = 0; i < TILE_SIZE; i++) begin
      mag      = abs_sat(y_axis_TDATA[i*DATA_WIDTH +: DATA_WIDTH]);
      tile_max = mag > tile_max ? mag : tile_max;
    end
  end
  // Running max is published together with vec_done, then restarts for the next vector.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run_max <= '0;
      maxabs  <= '0;
    end else if (soft_clr) run_max <= '0;
    else if (wr_done && last_line) begin
      maxabs  <= 16'(run_max);
      run_max <= '0;
    end else if (fire && tile_max > run_max) run_max <= tile_max;
`else
  assign maxabs = '0;
`endif
endmodule

// File: tb/tb_y_tile_pack_wb.sv
// tb_y_tile_pack_wb: directed self-checking bench for y_tile_pack_wb (default and YWB_MAXABS_EN builds).
module tb_y_tile_pack_wb;
  logic clk = 1'b0;
  logic rst_n, soft_clr, y_axis_TVALID, y_axis_TREADY, wr_en, wr_ready, vec_done, busy;
  logic [63:0]  y_axis_TDATA;
  logic [5:0]   wr_addr;
  logic [255:0] wr_data, last_data;
  logic [15:0]  vec_cnt, maxabs;
  logic [5:0]   log_addr [0:511];
  int checks = 0, failures = 0, n_wr = 0, n_vd = 0, n_en = 0, base, nw;
`ifdef YWB_MAXABS_EN
  localparam bit MAXEN = 1'b1;
`else
  localparam bit MAXEN = 1'b0;
`endif

  always #5 clk = ~clk;

  y_tile_pack_wb dut (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr),
    .y_axis_TVALID(y_axis_TVALID), .y_axis_TREADY(y_axis_TREADY), .y_axis_TDATA(y_axis_TDATA),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .vec_done(vec_done), .vec_cnt(vec_cnt), .busy(busy), .maxabs(maxabs)
  );

  always @(negedge clk)
    if (rst_n) begin
      if (wr_en && wr_ready) begin
        log_addr[n_wr] <= wr_addr;
        last_data      <= wr_data;
        n_wr           <= n_wr + 1;
      end
      if (vec_done) n_vd <= n_vd + 1;
      if (wr_en) n_en <= n_en + 1;
    end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Tile t of the REQ-018 pattern: lane i = 16*t + i.
  function automatic logic [63:0] tv(input int t);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = 16'(16 * t + i);
    return r;
  endfunction

  // Line built from tiles t0..t0+3: line lane j sits in tile j/4, lane j%4.
  function automatic logic [255:0] line_exp(input int t0);
    logic [255:0] r;
    for (int j = 0; j < 16; j++) r[j*16 +: 16] = 16'(16 * (t0 + j / 4) + j % 4);
    return r;
  endfunction

  task automatic send(input logic [63:0] d);
    int w;
    w = 0;
    y_axis_TVALID = 1'b1;
    y_axis_TDATA  = d;
    while (!y_axis_TREADY && w < 20) begin
      step();
      w++;
    end
    if (w >= 20) begin
      failures++;
      $display("FAIL tready_timeout observed=0 expected=1");
    end
    step();
    y_axis_TVALID = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; soft_clr = 1'b0; y_axis_TVALID = 1'b0; y_axis_TDATA = '0; wr_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    chk("rst_tready", y_axis_TREADY, 1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_vec", {vec_done, vec_cnt, maxabs}, 0);
    // Single line, buffer always ready
    for (int t = 0; t < 4; t++) send(tv(t));
    chk("a_wr_en", wr_en, 1);
    chk("a_addr", wr_addr, 0);
    chk("a_data", wr_data, line_exp(0));
    chk("a_tready", y_axis_TREADY, 0);
    chk("a_busy", busy, 1);
    step();
    chk("a_wr_en_low", wr_en, 0);
    chk("a_n_wr", n_wr, 1);
    chk("a_n_en", n_en, 1);
    chk("a_addr_next", wr_addr, 1);
    chk("a_data_clr", wr_data, 0);
    // Back-pressure: 5 stalled cycles, TVALID held but must not be consumed
    wr_ready = 1'b0;
    for (int t = 4; t < 8; t++) send(tv(t));
    y_axis_TVALID = 1'b1;
    y_axis_TDATA  = 64'hDEAD_BEEF_CAFE_F00D;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) begin
        wr_ready = 1'b1;
        y_axis_TVALID = 1'b0;
      end
      chk("b_wr_en", wr_en, 1);
      chk("b_addr", wr_addr, 1);
      chk("b_data", wr_data, line_exp(4));
      chk("b_tready", y_axis_TREADY, 0);
      step();
    end
    chk("b_n_wr", n_wr, 2);
    chk("b_n_en", n_en, 7);
    chk("b_wr_en_low", wr_en, 0);
    chk("b_busy", busy, 0);
    chk("b_last_data", last_data, line_exp(4));
    // One full vector after reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("c_rst_vec_cnt", vec_cnt, 0);
    base = n_wr;
    for (int t = 0; t < 64; t++) send(tv(t));
    chk("c_vd_before", vec_done, 0);
    step();
    chk("c_vec_done", vec_done, 1);
    chk("c_vec_cnt", vec_cnt, 1);
    chk("c_maxabs", maxabs, MAXEN ? 16'd1011 : 16'd0);
    step();
    chk("c_vd_pulse", vec_done, 0);
    chk("c_n_vd", n_vd, 1);
    chk("c_writes", n_wr - base, 16);
    chk("c_addr0", log_addr[base], 0);
    chk("c_addr15", log_addr[base + 15], 15);
    chk("c_last_data", last_data, line_exp(60));
    // Four more vectors: address wraps after the 64th write
    for (int t = 64; t < 320; t++) send(tv(t));
    step();
    step();
    chk("d_writes", n_wr - base, 80);
    chk("d_addr63", log_addr[base + 63], 63);
    chk("d_addr_wrap", log_addr[base + 64], 0);
    chk("d_vec_cnt", vec_cnt, 5);
    chk("d_n_vd", n_vd, 5);
    chk("d_wr_addr", wr_addr, 16);
    chk("d_maxabs", maxabs, MAXEN ? 16'd5107 : 16'd0);
    // Soft clear drops a partial line
    send(64'hAAAA_AAAA_AAAA_AAAA);
    send(64'hAAAA_AAAA_AAAA_AAAA);
    chk("e_busy_partial", busy, 1);
    soft_clr = 1'b1;
    step();
    soft_clr = 1'b0;
    chk("e_busy", busy, 0);
    chk("e_wr_en", wr_en, 0);
    chk("e_addr", wr_addr, 0);
    chk("e_data", wr_data, 0);
    chk("e_vec_cnt", vec_cnt, 5);
    nw = n_wr;
    for (int t = 0; t < 4; t++) send(tv(t));
    chk("e_addr_w", wr_addr, 0);
    chk("e_data_w", wr_data, line_exp(0));
    step();
    chk("e_n_wr", n_wr, nw + 1);
    // Saturating max |y| over one vector
    soft_clr = 1'b1;
    step();
    soft_clr = 1'b0;
    for (int t = 0; t < 64; t++) begin
      y_axis_TDATA = '0;
      send(t == 5 ? 64'h0000_8000_0000_0000 : t == 9 ? 64'h0000_0000_0000_1234 :
           t == 20 ? 64'h0000_0000_FFFB_0000 : 64'h0);
    end
    step();
    chk("f_vec_done", vec_done, 1);
    chk("f_vec_cnt", vec_cnt, 6);
    chk("f_maxabs", maxabs, MAXEN ? 16'd32767 : 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
